memory_write_unit: RTL and testbench



---
 rtl/memory_write_unit_pkg.sv | 26 ++
 rtl/memory_write_unit_store_aligner.sv | 34 +++
 rtl/memory_write_unit.sv | 153 +++++++++++++++
 tb/tb_memory_write_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/memory_write_unit_pkg.sv
// Shared store/load definitions: access-size codes, write-unit states and lane payload.
package memory_write_unit_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  // Size codes are shared with the load-side extension logic.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_FIN  = 2'b10
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } store_lane_t;

endpackage

// File: rtl/memory_write_unit_store_aligner.sv
// Places right-justified store data into byte lanes and flags misaligned or illegal accesses.
module store_aligner
  import memory_write_unit_pkg::*;
(
  input  logic [1:0]        addr_lo_i,
  input  logic [1:0]        size_i,
  input  logic [DATA_W-1:0] wdata_i,
  output store_lane_t       lane_o,
  output logic              misaligned_o
);

  always_comb begin
    lane_o       = '0;
    misaligned_o = 1'b0;
    case (size_e'(size_i))
      SZ_BYTE: begin
        lane_o.data = {4{wdata_i[7:0]}};
        lane_o.be   = 4'b0001 << addr_lo_i;
      end
      SZ_HALF: begin
        lane_o.data  = {2{wdata_i[15:0]}};
        lane_o.be    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        misaligned_o = addr_lo_i[0];
      end
      SZ_WORD: begin
        lane_o.data  = wdata_i;
        lane_o.be    = 4'b1111;
        misaligned_o = |addr_lo_i;
      end
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/memory_write_unit.sv
// Store-side memory unit: aligns a controller store request and runs the req/ack write
// handshake to data memory, reporting done/err back to the controller.
module memory_write_unit
  import memory_write_unit_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [1:0]        size,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [3:0]         mem_be_q, mem_be_d;

  store_lane_t lane;
  logic        misaligned;

  store_aligner u_aligner (
    .addr_lo_i    (addr[1:0]),
    .size_i       (size),
    .wdata_i      (wdata),
    .lane_o       (lane),
    .misaligned_o (misaligned)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;

    case (state_q)
      ST_IDLE: begin
        busy_d    = 1'b0;
        err_d     = 1'b0;
        mem_req_d = 1'b0;
        if (start) begin
          busy_d = 1'b1;
          if (misaligned) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d     = ST_REQ;
            mem_req_d   = 1'b1;
            mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = lane.data;
            mem_be_d    = lane.be;
            cnt_d       = '0;
          end
        end
      end
      ST_REQ: begin
        // Ack takes priority over a timeout landing on the same cycle.
        if (mem_ack) begin
          state_d   = ST_FIN;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b0;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          state_d   = ST_FIN;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        err_d   = 1'b0;
      end
      default: begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        err_d     = 1'b0;
        mem_req_d = 1'b0;
      end
    endcase

    mem_we_d = mem_req_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_memory_write_unit.sv
// Directed bench for memory_write_unit: alignment, misalignment, handshake hold, timeout, reset.
module tb_memory_write_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;

  int tests = 0;
  int fails = 0;

  memory_write_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .addr      (addr),
    .wdata     (wdata),
    .size      (size),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {busy, done, err, mem_req, mem_we}
  function automatic logic [4:0] ctl();
    return {busy, done, err, mem_req, mem_we};
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    start = 1'b1; addr = a; wdata = d; size = s;
    tick();
    start = 1'b0;
  endtask

  logic        held;
  logic [31:0] h_addr, h_data;
  logic [3:0]  h_be;

  initial begin
    reset = 1'b1; start = 1'b0; addr = '0; wdata = '0; size = 2'b00; mem_ack = 1'b0;
    tick(); tick();
    chk("reset_ctl",   64'(ctl()), 64'(5'b00000));
    chk("reset_addr",  64'(mem_addr), 64'h0);
    chk("reset_wdata", 64'(mem_wdata), 64'h0);
    chk("reset_be",    64'(mem_be), 64'h0);
    reset = 1'b0;
    tick();

    // Word store, ack on first REQ cycle
    issue(32'h0000_0010, 32'hDEAD_BEEF, 2'b10);
    chk("word_ctl",   64'(ctl()), 64'(5'b10011));
    chk("word_addr",  64'(mem_addr), 64'h10);
    chk("word_be",    64'(mem_be), 64'hF);
    chk("word_data",  64'(mem_wdata), 64'hDEAD_BEEF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("word_done",  64'(ctl()), 64'(5'b11000));
    tick();
    chk("word_idle",  64'(ctl()), 64'(5'b00000));

    // Byte store at lane 3
    issue(32'h0000_0013, 32'h0000_00A5, 2'b00);
    chk("byte3_addr", 64'(mem_addr), 64'h10);
    chk("byte3_be",   64'(mem_be), 64'h8);
    chk("byte3_data", 64'(mem_wdata), 64'hA5A5_A5A5);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    chk("byte3_done", 64'(ctl()), 64'(5'b11000));
    tick();

    // Byte store at lane 1, upper data bits ignored
    issue(32'h0000_0011, 32'hFFFF_FF3C, 2'b00);
    chk("byte1_be",   64'(mem_be), 64'h2);
    chk("byte1_data", 64'(mem_wdata), 64'h3C3C_3C3C);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0; tick();

    // Halfword, upper and lower
    issue(32'h0000_0012, 32'h0000_1234, 2'b01);
    chk("half_hi_addr", 64'(mem_addr), 64'h10);
    chk("half_hi_be",   64'(mem_be), 64'hC);
    chk("half_hi_data", 64'(mem_wdata), 64'h1234_1234);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    chk("half_hi_done", 64'(ctl()), 64'(5'b11000));
    tick();
    issue(32'h0000_0104, 32'hABCD_5678, 2'b01);
    chk("half_lo_addr", 64'(mem_addr), 64'h104);
    chk("half_lo_be",   64'(mem_be), 64'h3);
    chk("half_lo_data", 64'(mem_wdata), 64'h5678_5678);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0; tick();

    // Misaligned word, misaligned half, illegal size
    issue(32'h0000_0006, 32'h1111_2222, 2'b10);
    chk("misw_fin",  64'(ctl()), 64'(5'b11100));
    tick();
    chk("misw_idle", 64'(ctl()), 64'(5'b00000));
    issue(32'h0000_0001, 32'h0000_3333, 2'b01);
    chk("mish_fin",  64'(ctl()), 64'(5'b11100));
    tick();
    issue(32'h0000_0000, 32'h4444_5555, 2'b11);
    chk("ill_fin",   64'(ctl()), 64'(5'b11100));
    tick();
    chk("ill_idle",  64'(ctl()), 64'(5'b00000));

    // Ack in IDLE is ignored
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    chk("ack_idle", 64'(ctl()), 64'(5'b00000));

    // Ack withheld for 3 cycles; start during busy ignored
    issue(32'h0000_0020, 32'h0BAD_F00D, 2'b10);
    h_addr = mem_addr; h_data = mem_wdata; h_be = mem_be;
    chk("hold_c1", 64'({mem_req, mem_addr, mem_be}), 64'({1'b1, 32'h20, 4'hF}));
    start = 1'b1; addr = 32'h0000_0041; wdata = 32'h0000_0077; size = 2'b00;
    tick();
    start = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      if (i > 2) tick();
      chk($sformatf("hold_c%0d", i),
          64'({ctl(), mem_addr, mem_be}), 64'({5'b10011, h_addr, h_be}));
      chk($sformatf("hold_d%0d", i), 64'(mem_wdata), 64'(h_data));
    end
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    chk("hold_done", 64'(ctl()), 64'(5'b11000));
    start = 1'b1; addr = 32'h0; size = 2'b10;
    tick();
    start = 1'b0;
    chk("fin_start_ignored", 64'(ctl()), 64'(5'b00000));
    tick();
    chk("fin_start_stays", 64'(ctl()), 64'(5'b00000));

    // Timeout: no ack, mem_req high for exactly 16 cycles
    issue(32'h0000_0030, 32'hCAFE_0001, 2'b10);
    held = mem_req;
    for (int i = 0; i < 15; i++) begin
      tick();
      held = held & mem_req & ~done;
    end
    chk("to_hold16", 64'(held), 64'h1);
    tick();
    chk("to_fin", 64'(ctl()), 64'(5'b11100));
    tick();
    chk("to_idle", 64'(ctl()), 64'(5'b00000));

    // Ack on the final timeout cycle wins
    issue(32'h0000_0030, 32'hCAFE_0002, 2'b10);
    for (int i = 0; i < 15; i++) tick();
    chk("race_req", 64'(mem_req), 64'h1);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    chk("race_fin", 64'(ctl()), 64'(5'b11000));
    tick();

    // Asynchronous reset while in REQ
    issue(32'h0000_0050, 32'h5555_AAAA, 2'b10);
    chk("rst_pre", 64'(mem_req), 64'h1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_ctl", 64'(ctl()), 64'(5'b00000));
    chk("rst_async_be",  64'(mem_be), 64'h0);
    tick();
    reset = 1'b0;
    tick();
    issue(32'h0000_0060, 32'h0102_0304, 2'b10);
    chk("post_rst_req",  64'({ctl(), mem_addr, mem_be}), 64'({5'b10011, 32'h60, 4'hF}));
    chk("post_rst_data", 64'(mem_wdata), 64'h0102_0304);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    chk("post_rst_done", 64'(ctl()), 64'(5'b11000));
    tick();
    chk("post_rst_idle", 64'(ctl()), 64'(5'b00000));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
